// File: rtl/stream_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stream_pkg : types and default widths shared by stream_gen / stream_check.
// Rev 1.0
// ----------------------------------------------------------------------------
package stream_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_KEEP_W    = DEF_DATA_W / 8;
  localparam int DEF_ERR_CNT_W = 16;

  typedef struct packed {
    logic data;
    logic keep;
    logic last;
  } err_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic any_err(input err_t e);
    return e.data | e.keep | e.last;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_pacer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stream_pacer : issues one ready credit every rate+1 clocks while run is high.
// Rev 1.0
// ----------------------------------------------------------------------------
module stream_pacer (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        run,
  input  logic [15:0] rate,
  input  logic        take,
  output logic        credit
);

  logic [15:0] cnt_q;
  logic        credit_q;

  // >= rather than == so a rate lowered mid-count still wraps promptly.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q    <= '0;
      credit_q <= 1'b0;
    end else if (!run) begin
      cnt_q    <= '0;
      credit_q <= 1'b0;
    end else if (cnt_q >= rate) begin
      cnt_q    <= '0;
      credit_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 16'd1;
      if (take) credit_q <= 1'b0;
    end
  end

  assign credit = credit_q;

endmodule
`default_nettype wire

// File: rtl/stream_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stream_check : paced AXI4-Stream sink verifying counting payload, tkeep, tlast.
// Rev 1.0
// ----------------------------------------------------------------------------
module stream_check
  import stream_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [31:0]           frame_size,
  input  logic [15:0]           data_rate,
  input  logic [DATA_W-1:0]     tdata,
  input  logic [DATA_W/8-1:0]   tkeep,
  input  logic                  tlast,
  input  logic                  tvalid,
  output logic                  tready,
  output logic [31:0]           frame_count,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  err_sticky,
  output logic                  err_pulse,
  output logic [DATA_W-1:0]     first_err
);

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     exp_q, first_err_q;
  logic [31:0]           beat_q, beat_d, fsz_q, fsz_cur, frame_cnt_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic                  sticky_q, pulse_q;
  logic                  credit, hs, pacer_run;
  err_t                  err;

  assign hs        = tvalid & credit;
  assign fsz_cur   = (beat_q == 32'd0) ? frame_size : fsz_q;
  assign pacer_run = (state_d != IDLE);

  always_comb begin
    err.data = (tdata != exp_q);
    err.keep = (tkeep != '1);
    err.last = tlast ? (beat_q != fsz_cur) : (beat_q == fsz_cur);
  end

  always_comb begin
    beat_d = beat_q;
    if (clear)   beat_d = '0;
    else if (hs) beat_d = tlast ? 32'd0 : beat_q + 32'd1;
  end

  // Leaving RUN looks at the post-handshake beat so a tlast accepted in the
  // same cycle enable drops does not strand the sink in DRAIN for a frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = (beat_d != 32'd0) ? DRAIN : IDLE;
      DRAIN:   if (hs && tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  stream_pacer u_pacer (
    .clk     (clk),
    .aresetn (aresetn),
    .run     (pacer_run),
    .rate    (data_rate),
    .take    (hs),
    .credit  (credit)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      beat_q      <= '0;
      fsz_q       <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      sticky_q    <= 1'b0;
      pulse_q     <= 1'b0;
      first_err_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      pulse_q <= 1'b0;
      if (clear) begin
        exp_q       <= '0;
        frame_cnt_q <= '0;
        err_cnt_q   <= '0;
        sticky_q    <= 1'b0;
        first_err_q <= '0;
      end else if (hs) begin
        exp_q <= tdata + DATA_W'(1);
        if (beat_q == 32'd0) fsz_q <= frame_size;
        if (tlast) frame_cnt_q <= frame_cnt_q + 32'd1;
        if (any_err(err)) begin
          pulse_q  <= 1'b1;
          sticky_q <= 1'b1;
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
          if (!sticky_q) first_err_q <= tdata;
        end
      end
    end
  end

  assign tready      = credit;
  assign frame_count = frame_cnt_q;
  assign err_count   = err_cnt_q;
  assign err_sticky  = sticky_q;
  assign err_pulse   = pulse_q;
  assign first_err   = first_err_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stream_check : directed + randomized bench for stream_check with a beat-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_stream_check;

  localparam int EW = 8;  // narrow error counter so saturation is reachable quickly

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [31:0]   frame_size = '0;
  logic [15:0]   data_rate = '0;
  logic [31:0]   tdata = '0;
  logic [3:0]    tkeep = 4'hF;
  logic          tlast = 1'b0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [31:0]   frame_count;
  logic [EW-1:0] err_count;
  logic          err_sticky;
  logic          err_pulse;
  logic [31:0]   first_err;

  stream_check #(.DATA_W(32), .ERR_CNT_W(EW)) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .clear(clear),
    .frame_size(frame_size), .data_rate(data_rate),
    .tdata(tdata), .tkeep(tkeep), .tlast(tlast), .tvalid(tvalid), .tready(tready),
    .frame_count(frame_count), .err_count(err_count), .err_sticky(err_sticky),
    .err_pulse(err_pulse), .first_err(first_err)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_fail = 0;
  longint cyc = 0;
  int     pulse_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (err_pulse === 1'b1) pulse_seen <= pulse_seen + 1;

  // Reference model, one call per accepted beat.
  logic [31:0] m_exp = '0, m_beat = '0, m_fsz = '0, m_frames = '0, m_first = '0;
  int          m_errs = 0, m_pulses = 0;
  bit          m_sticky = 1'b0, last_bad = 1'b0;

  function automatic void model_clear();
    m_exp = '0; m_beat = '0; m_frames = '0; m_first = '0; m_errs = 0; m_sticky = 1'b0;
  endfunction

  function automatic void model_beat(input logic [31:0] d, input logic [3:0] k,
                                     input logic l, input logic [31:0] fs);
    bit bad;
    if (m_beat == 0) m_fsz = fs;
    bad = (d != m_exp) || (k != 4'hF) || (l != (m_beat == m_fsz));
    m_exp  = d + 1;
    m_beat = l ? 32'd0 : m_beat + 1;
    if (l) m_frames = m_frames + 1;
    if (bad) begin
      m_pulses++;
      if (m_errs < (1 << EW) - 1) m_errs++;
      if (!m_sticky) m_first = d;
      m_sticky = 1'b1;
    end
    last_bad = bad;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_frames"}, frame_count, m_frames);
    chk({tag, "_errs"},   32'(err_count), 32'(m_errs));
    chk({tag, "_sticky"}, 32'(err_sticky), 32'(m_sticky));
    chk({tag, "_first"},  first_err, m_first);
    chk({tag, "_pulses"}, 32'(pulse_seen), 32'(m_pulses));
  endtask

  longint last_hs = -1;
  longint gap_min = 0, gap_max = 0;

  task automatic gap_reset();
    last_hs = -1; gap_min = 1000000; gap_max = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int waited = 0;
    bit ok = 1'b1;
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (tready === 1'b1) break;
      waited++;
      if (waited > 100) begin
        n_cmp++; n_fail++;
        $error("FAIL hs_timeout: tready observed low for %0d clocks, expected a credit", waited);
        ok = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    if (ok) begin
      if (clear) model_clear();
      else model_beat(d, k, l, frame_size);
      if (last_hs >= 0) begin
        if (cyc - last_hs < gap_min) gap_min = cyc - last_hs;
        if (cyc - last_hs > gap_max) gap_max = cyc - last_hs;
      end
      last_hs = cyc;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1; idle(1); clear = 1'b0; model_clear();
  endtask

  initial begin
    logic [31:0] d, fs_now;
    logic [3:0]  k;
    logic        l;
    gap_reset();

    // Reset state
    idle(3);
    chk("rst_tready", 32'(tready), 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_errs", 32'(err_count), 0);
    chk("rst_sticky", 32'(err_sticky), 0);
    chk("rst_first", first_err, 0);
    chk("rst_pulse", 32'(err_pulse), 0);
    aresetn = 1'b1;
    idle(2);
    chk("idle_tready", 32'(tready), 0);

    // T1: full rate, two 512-beat frames
    frame_size = 511; data_rate = 0; enable = 1'b1; gap_reset();
    for (int i = 0; i < 1024; i++) send(i, 4'hF, (i % 512) == 511);
    idle(3);
    chk("t1_frames_const", frame_count, 2);
    chk("t1_errs_const", 32'(err_count), 0);
    chk("t1_gap_max", 32'(gap_max), 1);
    check_model("t1");

    // T2: rate 3 -> one beat every 4 clocks
    pulse_clear();
    data_rate = 3; frame_size = 15; gap_reset();
    for (int i = 0; i < 16; i++) send(i, 4'hF, i == 15);
    idle(3);
    chk("t2_gap_min", 32'(gap_min), 4);
    chk("t2_gap_max", 32'(gap_max), 4);
    chk("t2_frames_const", frame_count, 1);
    check_model("t2");

    // clear coincident with a handshake discards the beat
    data_rate = 0; frame_size = 511;
    clear = 1'b1;
    send(32'h12345, 4'hF, 1'b1);
    clear = 1'b0;
    chk("clrhs_frames", frame_count, 0);
    chk("clrhs_errs", 32'(err_count), 0);

    // T3: corrupted word 100, resync at 102
    for (int i = 0; i < 512; i++) begin
      send((i == 100) ? 32'hDEAD : 32'(i), 4'hF, i == 511);
      if (i >= 100 && i <= 102)
        chk($sformatf("t3_pulse%0d", i), 32'(err_pulse), (i != 102) ? 32'd1 : 32'd0);
    end
    idle(3);
    chk("t3_errs_const", 32'(err_count), 2);
    chk("t3_first_const", first_err, 32'hDEAD);
    check_model("t3");

    // T4: early tlast, ignored mid-frame size change, bad tkeep, missing and late tlast
    pulse_clear();
    frame_size = 511;
    for (int i = 0; i < 256; i++) send(i, 4'hF, i == 255);
    idle(1);
    chk("t4_frames_early", frame_count, 1);
    for (int i = 0; i < 520; i++) begin
      if (i == 10) frame_size = 7;
      send(256 + i, (i == 40) ? 4'h7 : 4'hF, i == 519);
    end
    idle(3);
    chk("t4_errs_const", 32'(err_count), 4);
    chk("t4_frames_const", frame_count, 2);
    check_model("t4");

    // T5: enable drop at beat 300 drains through tlast
    pulse_clear();
    frame_size = 511;
    for (int i = 0; i < 300; i++) send(i, 4'hF, 1'b0);
    enable = 1'b0;
    for (int i = 300; i < 512; i++) send(i, 4'hF, i == 511);
    chk("t5_tready_drained", 32'(tready), 0);
    tvalid = 1'b1; idle(5); tvalid = 1'b0;
    chk("t5_tready_idle", 32'(tready), 0);
    chk("t5_frames_const", frame_count, 1);
    check_model("t5");

    // saturation of the error counter, then clear
    enable = 1'b1;
    for (int i = 0; i < 300; i++) send(i + 7, 4'h0, 1'b0);
    idle(3);
    chk("sat_errs_const", 32'(err_count), (1 << EW) - 1);
    check_model("sat");
    pulse_clear();
    chk("satclr_errs", 32'(err_count), 0);
    chk("satclr_sticky", 32'(err_sticky), 0);
    chk("satclr_first", first_err, 0);

    // mid-frame asynchronous reset
    for (int i = 0; i < 50; i++) send(1000 + i, 4'hF, 1'b0);
    idle(2);
    chk("pre_rst_first", first_err, 1000);
    #3 aresetn = 1'b0;
    #1;
    chk("arst_tready", 32'(tready), 0);
    chk("arst_errs", 32'(err_count), 0);
    chk("arst_sticky", 32'(err_sticky), 0);
    chk("arst_first", first_err, 0);
    model_clear();
    idle(2);
    aresetn = 1'b1;
    frame_size = 3;
    for (int i = 0; i < 4; i++) send(i, 4'hF, i == 3);
    idle(3);
    chk("postrst_frames_const", frame_count, 1);
    check_model("postrst");

    // T6: randomized gaps, rates, and error injection
    pulse_clear();
    for (int r = 0; r < 4; r++) begin
      data_rate  = 16'($urandom_range(0, 7));
      frame_size = 32'($urandom_range(2, 12));
      for (int b = 0; b < 80; b++) begin
        idle($urandom_range(0, 3));
        fs_now = (m_beat == 0) ? frame_size : m_fsz;
        d = ($urandom_range(0, 11) == 0) ? $urandom : m_exp;
        k = ($urandom_range(0, 19) == 0) ? 4'hE : 4'hF;
        l = (m_beat == fs_now) ^ ($urandom_range(0, 14) == 0);
        send(d, k, l);
        chk("t6_pulse", 32'(err_pulse), 32'(last_bad));
      end
      idle(3);
      check_model($sformatf("t6r%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
